mux_scan: RTL and testbench

- Parametrised, registered N:1 channel multiplexer with a valid/ready output stage.
- Manual mode: a registered select, one sample per accepted beat.
- Scan mode: a sequencer walks every channel enabled in a mask, in ascending order, one channel per accepted beat, and signals completion.
- Sits between wide multi-channel sources and a single serial consumer; replaces the fixed 16:1 combinational select.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_next_chan_find.sv | 34 +++
 rtl/mux_scan.sv | 164 ++++++++++++++++
 tb/tb_mux_scan.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and mode constants for mux_scan
//
// Contents:
//   state_t      sequencer states (IDLE, SCAN, DONE)
//   MODE_MANUAL  mode input value selecting the registered manual select
//   MODE_SCAN    mode input value selecting the mask-driven scan sequencer
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_next_chan_find.sv
// rtl/mux_scan_next_chan_find.sv - lowest enabled channel strictly above an index
//
// Ports:
//   mask   in   N_CH   channel enable mask
//   idx    in   SEL_W  search starts strictly above this channel
//   first  in   1      treat idx as -1 (search from channel 0 inclusive)
//   nxt    out  SEL_W  lowest set mask bit above idx (0 when none)
//   found  out  1      a set bit exists above idx
module next_chan_find
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 16,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] idx,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Walk downward so the last hit written is the lowest qualifying channel.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask[k] && (first || (k > int'(idx)))) begin
        nxt   = SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N:1 channel mux with manual select and mask scan
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in         in   N_CH*DW    packed channel data, channel k = in[k*DW +: DW]
//   mode       in   1          MODE_MANUAL / MODE_SCAN, sampled only in IDLE
//   sel_in     in   SEL_W      manual channel index
//   en_mask    in   N_CH       scan enable mask, latched on scan start
//   start      in   1          scan start request (pulse or level)
//   out        out  DW         registered channel sample
//   out_sel    out  SEL_W      channel index held in out
//   out_valid  out  1          out/out_sel hold a beat
//   out_ready  in   1          consumer accepts when out_valid && out_ready
//   busy       out  1          sequencer is in SCAN
//   done       out  1          one-cycle pulse at end of scan
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N_CH  = 16,
  parameter  int DW    = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*DW-1:0]   in,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel_in,
  input  logic [N_CH-1:0]      en_mask,
  input  logic                 start,
  output logic [DW-1:0]        out,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              free;
  logic              load;
  logic [SEL_W-1:0]  load_ch;
  logic [DW-1:0]     load_data;
  logic              sel_ok;

  logic [SEL_W-1:0]  first_ch, next_ch;
  logic              first_found, next_found;

  // The output register can take a new beat when empty or being drained.
  assign free = !out_valid || out_ready;

  // With non-power-of-two N_CH some select codes name no channel.
  assign sel_ok = int'(sel_in) < N_CH;

  // Initial pointer: searched over the live mask so SCAN starts on its
  // first enabled channel without an extra lookup cycle.
  next_chan_find #(.N_CH(N_CH)) u_first (
    .mask  (en_mask),
    .idx   ('0),
    .first (1'b1),
    .nxt   (first_ch),
    .found (first_found)
  );

  // Successor of the channel being loaded this cycle; skipping disabled
  // channels here is what makes them cost zero cycles.
  next_chan_find #(.N_CH(N_CH)) u_next (
    .mask  (mask_q),
    .idx   (ptr_q),
    .first (1'b0),
    .nxt   (next_ch),
    .found (next_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    load_ch = ptr_q;

    case (state_q)
      IDLE: begin
        if (mode == MODE_SCAN) begin
          // Scan start may coincide with an unaccepted manual beat; SCAN
          // simply waits for free before its first load.
          if (start) begin
            mask_d  = en_mask;
            ptr_d   = first_ch;
            state_d = first_found ? SCAN : DONE;
          end
        end else if (free && sel_ok) begin
          load    = 1'b1;
          load_ch = sel_in;
        end
      end

      SCAN: begin
        if (free) begin
          load    = 1'b1;
          load_ch = ptr_q;
          if (next_found) begin
            ptr_d = next_ch;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    load_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (load_ch == SEL_W'(k)) begin
        load_data = in[k*DW +: DW];
      end
    end
  end

  // A free edge without a load empties the register; a stalled edge holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (free) begin
      if (load) begin
        out       <= load_data;
        out_sel   <= load_ch;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q == SCAN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - scoreboard bench for mux_scan
module tb_mux_scan;

  localparam int N_CH  = 16;
  localparam int DW    = 1;
  localparam int SEL_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_CH*DW-1:0]  in;
  logic                mode;
  logic [SEL_W-1:0]    sel_in;
  logic [N_CH-1:0]     en_mask;
  logic                start;
  logic [DW-1:0]       out;
  logic [SEL_W-1:0]    out_sel;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  mux_scan #(.N_CH(N_CH), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .mode      (mode),
    .sel_in    (sel_in),
    .en_mask   (en_mask),
    .start     (start),
    .out       (out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [DW-1:0]    data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_beat(input int ch);
    beat_t b;
    b.sel  = SEL_W'(ch);
    b.data = in[ch*DW +: DW];
    exp_q.push_back(b);
  endtask

  // Reference: a scan emits every enabled channel once, ascending, sampled
  // from the data present when the scan runs.
  task automatic expect_scan(input logic [N_CH-1:0] m);
    for (int k = 0; k < N_CH; k++) begin
      if (m[k]) push_beat(k);
    end
  endtask

  task automatic start_scan(input logic [N_CH-1:0] m);
    step();
    mode    = 1'b1;
    en_mask = m;
    start   = 1'b1;
    expect_scan(m);
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      sample();
      if (done) begin
        seen = 1'b1;
      end else begin
        step();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic drain();
    step();
    out_ready = 1'b1;
    step();
    step();
    sample();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);
  endtask

  // Monitor: pops a predicted beat for each accepted handshake, checks that
  // a stalled beat is held, and that done never lasts two cycles.
  initial begin
    bit                stall_q;
    bit                prev_done;
    logic [DW-1:0]     out_h;
    logic [SEL_W-1:0]  sel_h;
    stall_q   = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q   = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_sel", 32'(out_sel), 32'(sel_h));
          check("hold_data", 32'(out), 32'(out_h));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(out_sel), 32'hffff_ffff);
          end else begin
            mon_b = exp_q.pop_front();
            check("beat_sel", 32'(out_sel), 32'(mon_b.sel));
            check("beat_data", 32'(out), 32'(mon_b.data));
          end
        end
        if (done && prev_done) check("done_width", 32'd2, 32'd1);
        prev_done = done;
        stall_q   = out_valid && !out_ready;
        sel_h     = out_sel;
        out_h     = out;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0]   held8;
    logic [N_CH-1:0] m;
    int              len;

    rst_n     = 1'b0;
    in        = '0;
    mode      = 1'b1;
    sel_in    = '0;
    en_mask   = '0;
    start     = 1'b0;
    out_ready = 1'b1;

    #3;
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;

    // Manual sweep over all channels.
    in = 16'h300E;
    for (int s = 0; s < N_CH; s++) begin
      step();
      mode   = 1'b0;
      sel_in = SEL_W'(s);
      push_beat(s);
      if (s > 0) begin
        sample();
        check("manual_valid", 32'(out_valid), 32'd1);
        check("manual_lat", 32'(out_sel), 32'(s - 1));
      end
    end
    step();
    mode = 1'b1;
    drain();

    // Full scan: busy throughout, done right after the last load.
    in = 16'hA5C3;
    start_scan(16'hFFFF);
    sample();
    check("full_busy_start", 32'(busy), 32'd1);
    for (int k = 1; k <= N_CH; k++) begin
      sample();
      if (k < N_CH) begin
        check("full_busy", 32'(busy), 32'd1);
        check("full_sel", 32'(out_sel), 32'(k - 1));
      end else begin
        check("full_done", 32'(done), 32'd1);
        check("full_busy_end", 32'(busy), 32'd0);
        check("full_last_sel", 32'(out_sel), 32'd15);
      end
    end
    sample();
    check("full_done_clear", 32'(done), 32'd0);
    check("full_valid_clear", 32'(out_valid), 32'd0);
    drain();

    // Sparse scan with backpressure at channel 8.
    in = 16'h7F3C;
    held8 = in[8];
    start_scan(16'h8101);
    sample();
    sample();
    check("sparse_sel0", 32'(out_sel), 32'd0);
    step();
    out_ready = 1'b0;
    sample();
    check("sparse_sel8", 32'(out_sel), 32'd8);
    for (int i = 0; i < 3; i++) begin
      step();
      in[8] = ~in[8];
    end
    out_ready = 1'b1;
    sample();
    check("bp_sel_held", 32'(out_sel), 32'd8);
    check("bp_data_held", 32'(out), 32'(held8));
    sample();
    check("bp_next_sel", 32'(out_sel), 32'd15);
    check("sparse_done", 32'(done), 32'd1);
    drain();

    // Empty mask: done with no beat, never busy.
    start_scan('0);
    sample();
    check("empty_done", 32'(done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_valid", 32'(out_valid), 32'd0);
    drain();

    // Reset in the middle of a full scan.
    in = 16'h1234;
    start_scan(16'hFFFF);
    sample();
    for (int i = 0; i < 9; i++) sample();
    check("pre_rst_sel", 32'(out_sel), 32'd8);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_sel", 32'(out_sel), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    in = 16'hFFFF;
    start_scan(16'h0003);
    wait_done(1'b0);
    drain();

    // Randomized segments: manual runs and scans under random backpressure.
    for (int seg = 0; seg < 30; seg++) begin
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, 20);
        in  = N_CH'($urandom);
        for (int i = 0; i < len; i++) begin
          step();
          mode   = 1'b0;
          sel_in = SEL_W'($urandom_range(0, N_CH - 1));
          push_beat(int'(sel_in));
        end
        step();
        mode = 1'b1;
        drain();
      end else begin
        in = N_CH'($urandom);
        m  = N_CH'($urandom) & N_CH'($urandom);
        if ($urandom_range(0, 7) == 0) m = '0;
        start_scan(m);
        wait_done(1'b1);
        drain();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
